// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: IDLE -> FETCH -> DECODE -> EXEC [-> MEM] -> FETCH; state_o encodes 0..5 in that order, HALT=5.
// Optional macro CTRL_MEM_TIMEOUT_EN: halt after MEM_TIMEOUT unacknowledged memory wait cycles.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [4:0]  flags,
  input  logic        memAck,
  output logic        memReq,
  output logic        memWe,
  output logic        addrSel,
  output logic        irEn,
  output logic        srcEn,
  output logic        dstEn,
  output logic        immEn,
  output logic        regWrite,
  output logic        flagsEn,
  output logic        pcEn,
  output logic [1:0]  pcSel,
  output logic [1:0]  wbSel,
  output logic [3:0]  aluOp,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_REG, C_IMM, C_SHIFT, C_LOAD, C_STOR, C_JAL, C_JCOND, C_BCOND
  } cls_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_CMP = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;
  localparam logic [3:0] ALU_LSH = 4'b1000;

  state_e      state_q, state_d;
  logic [11:0] ir_q, ir_d;
  logic [3:0]  op, cond, ext;
  cls_e        cls;
  logic [3:0]  alu_op;
  logic        set_flags, is_cmp, cond_true, to_hit;
  logic [6:0]  sel_reg, sel_imm;
  logic        unused_instr_lo;

  // Register-form ext codes and immediate-form opcodes share one table: {ok, set_flags, is_cmp, aluOp}.
  function automatic logic [6:0] alu_sel(input logic [3:0] code);
    logic [6:0] r;
    r = '0;
    case (code)
      4'b0101: r = {3'b110, ALU_ADD};
      4'b1001: r = {3'b110, ALU_SUB};
      4'b1011: r = {3'b111, ALU_CMP};
      4'b0001: r = {3'b100, ALU_AND};
      4'b0010: r = {3'b100, ALU_OR};
      4'b0011: r = {3'b100, ALU_XOR};
      4'b1101: r = {3'b100, ALU_MOV};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op              = ir_q[11:8];
  assign cond            = ir_q[7:4];
  assign ext             = ir_q[3:0];
  assign unused_instr_lo = ^instr[3:0];
  assign state_o         = state_q;
  assign sel_reg         = alu_sel(ext);
  assign sel_imm         = alu_sel(op);

  always_comb begin
    cls       = C_ILL;
    alu_op    = ALU_ADD;
    set_flags = 1'b0;
    is_cmp    = 1'b0;
    case (op)
      4'b0000: if (sel_reg[6]) begin
        cls = C_REG;
        {set_flags, is_cmp, alu_op} = sel_reg[5:0];
      end
      4'b1000: if (ext inside {4'b0000, 4'b0001, 4'b0100}) begin
        cls    = C_SHIFT;
        alu_op = ALU_LSH;
      end
      4'b0100: begin
        case (ext)
          4'b0000: cls = C_LOAD;
          4'b0100: cls = C_STOR;
          4'b1000: cls = C_JAL;
          4'b1100: cls = C_JCOND;
          default: cls = C_ILL;
        endcase
      end
      4'b1100: cls = C_BCOND;
      4'b1111: begin
        cls    = C_IMM;
        alu_op = ALU_LUI;
      end
      default: if (sel_imm[6]) begin
        cls = C_IMM;
        {set_flags, is_cmp, alu_op} = sel_imm[5:0];
      end
    endcase
  end

  // flags = {C, L, F, Z, N}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = flags[1];
      4'h1: cond_true = !flags[1];
      4'h2: cond_true = flags[4];
      4'h3: cond_true = !flags[4];
      4'h4: cond_true = flags[3];
      4'h5: cond_true = !flags[3];
      4'h6: cond_true = flags[0];
      4'h7: cond_true = !flags[0];
      4'h8: cond_true = flags[2];
      4'h9: cond_true = !flags[2];
      4'hA: cond_true = !flags[3] && !flags[1];
      4'hB: cond_true = flags[3] || flags[1];
      4'hC: cond_true = !flags[0] && !flags[1];
      4'hD: cond_true = flags[0] || flags[1];
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            mem_wait;
  assign mem_wait = (state_q == S_FETCH || state_q == S_MEM) && !memAck;
  assign to_hit   = mem_wait && (to_q == TO_W'(MEM_TIMEOUT - 1));
  assign halted   = (state_q == S_HALT);
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (MEM_TIMEOUT < (1 << TO_W));
  assign to_hit        = 1'b0;
  assign halted        = 1'b0;
`endif

  // memReq holds until the cycle memAck is seen; that same cycle completes the access.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (memAck) begin
          state_d = S_DECODE;
          ir_d    = instr[15:4];
        end else if (to_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (cls == C_LOAD || cls == C_STOR) ? S_MEM : S_FETCH;
      S_MEM: begin
        if (memAck)      state_d = S_FETCH;
        else if (to_hit) state_d = S_HALT;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    to_d = to_q;
    if (mem_wait) to_d = to_q + 1'b1;
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) to_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
`ifdef CTRL_MEM_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    memReq   = 1'b0;
    memWe    = 1'b0;
    addrSel  = 1'b0;
    irEn     = 1'b0;
    srcEn    = 1'b0;
    dstEn    = 1'b0;
    immEn    = 1'b0;
    regWrite = 1'b0;
    flagsEn  = 1'b0;
    pcEn     = 1'b0;
    pcSel    = 2'd0;
    wbSel    = 2'd0;
    aluOp    = 4'd0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq = 1'b1;
        irEn   = memAck;
      end
      S_DECODE: begin
        case (cls)
          C_REG, C_SHIFT: begin
            srcEn = 1'b1;
            dstEn = 1'b1;
          end
          C_IMM: begin
            immEn = 1'b1;
            dstEn = 1'b1;
          end
          C_LOAD, C_STOR, C_JAL, C_JCOND: dstEn = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_REG, C_IMM, C_SHIFT: begin
            aluOp    = alu_op;
            regWrite = !is_cmp;
            flagsEn  = set_flags;
            pcEn     = 1'b1;
          end
          C_BCOND: begin
            pcEn  = 1'b1;
            pcSel = cond_true ? 2'd1 : 2'd0;
          end
          C_JCOND: begin
            pcEn  = 1'b1;
            pcSel = cond_true ? 2'd2 : 2'd0;
          end
          C_JAL: begin
            regWrite = 1'b1;
            wbSel    = 2'd2;
            pcEn     = 1'b1;
            pcSel    = 2'd2;
          end
          C_ILL: begin
            illegal = 1'b1;
            pcEn    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        memReq  = 1'b1;
        addrSel = 1'b1;
        memWe   = (cls == C_STOR);
        if (memAck) begin
          pcEn     = 1'b1;
          regWrite = (cls == C_LOAD);
          wbSel    = (cls == C_LOAD) ? 2'd1 : 2'd0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control vectors go through an expected queue.
// Timeout scenarios are exercised when CTRL_MEM_TIMEOUT_EN is defined for the build.
module tb_multicycle_controller;

  localparam int TMO = 15;
  localparam int VW  = 23;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_HALT = 3'd5;

  // Enable bits: memReq memWe addrSel irEn srcEn dstEn immEn regWrite flagsEn pcEn
  localparam logic [9:0] E_MREQ = 10'b1000000000;
  localparam logic [9:0] E_MWE  = 10'b0100000000;
  localparam logic [9:0] E_ASEL = 10'b0010000000;
  localparam logic [9:0] E_IREN = 10'b0001000000;
  localparam logic [9:0] E_SRC  = 10'b0000100000;
  localparam logic [9:0] E_DST  = 10'b0000010000;
  localparam logic [9:0] E_IMM  = 10'b0000001000;
  localparam logic [9:0] E_RW   = 10'b0000000100;
  localparam logic [9:0] E_FL   = 10'b0000000010;
  localparam logic [9:0] E_PC   = 10'b0000000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic [4:0]  flags = '0;
  logic        memAck = 1'b0;
  logic        memReq, memWe, addrSel, irEn, srcEn, dstEn, immEn;
  logic        regWrite, flagsEn, pcEn, illegal, halted;
  logic [1:0]  pcSel, wbSel;
  logic [3:0]  aluOp;
  logic [2:0]  state_o;

  logic [VW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .memAck(memAck),
    .memReq(memReq), .memWe(memWe), .addrSel(addrSel), .irEn(irEn),
    .srcEn(srcEn), .dstEn(dstEn), .immEn(immEn), .regWrite(regWrite),
    .flagsEn(flagsEn), .pcEn(pcEn), .pcSel(pcSel), .wbSel(wbSel),
    .aluOp(aluOp), .illegal(illegal), .halted(halted), .state_o(state_o)
  );

  function automatic logic [VW-1:0] pk(input logic [2:0] st, input logic [9:0] en,
                                       input logic [1:0] ps, input logic [1:0] ws,
                                       input logic [3:0] op, input logic il, input logic hl);
    return {st, en, ps, ws, op, il, hl};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {state_o, memReq, memWe, addrSel, irEn, srcEn, dstEn, immEn, regWrite,
            flagsEn, pcEn, pcSel, wbSel, aluOp, illegal, halted};
  endfunction

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (state,en10,pcSel,wbSel,aluOp,illegal,halted)",
               tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sample on the falling edge, return just after the next rising edge.
  task automatic cyc(input logic [15:0] ins, input logic [4:0] fl, input logic ack,
                     input logic [VW-1:0] exp, input string tag);
    instr  = ins;
    flags  = fl;
    memAck = ack;
    exp_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, observed(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ins, input int waits);
    for (int i = 0; i < waits; i++)
      cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_FETCH, E_MREQ, 0, 0, 0, 0, 0), "fetch_wait");
    cyc(ins, 5'($urandom), 1'b1, pk(ST_FETCH, E_MREQ | E_IREN, 0, 0, 0, 0, 0), "fetch_ack");
  endtask

  task automatic run_exec(input logic [15:0] ins, input logic [4:0] fl, input int fw,
                          input logic [9:0] dec_en, input logic [VW-1:0] exec_exp, input string tag);
    fetch(ins, fw);
    cyc(16'($urandom), 5'($urandom), 1'($urandom), pk(ST_DECODE, dec_en, 0, 0, 0, 0, 0), {tag, "_dec"});
    cyc(16'($urandom), fl, 1'($urandom), exec_exp, {tag, "_exec"});
  endtask

  task automatic mem_phase(input logic we, input logic ld, input int waits, input string tag);
    logic [9:0] base;
    base = E_MREQ | E_ASEL | (we ? E_MWE : 10'b0);
    for (int i = 0; i < waits; i++)
      cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_MEM, base, 0, 0, 0, 0, 0), {tag, "_mwait"});
    cyc(16'($urandom), 5'($urandom), 1'b1,
        pk(ST_MEM, base | E_PC | (ld ? E_RW : 10'b0), 2'd0, ld ? 2'd1 : 2'd0, 0, 0, 0), {tag, "_mack"});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(16'($urandom), 5'($urandom), 1'b1, pk(ST_IDLE, 0, 0, 0, 0, 0, 0), tag);
    reset = 1'b0;
    cyc(16'($urandom), 5'($urandom), 1'($urandom), pk(ST_IDLE, 0, 0, 0, 0, 0, 0), {tag, "_idle"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc(16'h0000, 5'b0, 1'b0, pk(ST_IDLE, 0, 0, 0, 0, 0, 0), "reset_state");
    reset = 1'b0;
    cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_IDLE, 0, 0, 0, 0, 0, 0), "idle");

    // ALU register and immediate forms
    run_exec(16'h0152, 5'($urandom), 0, E_SRC | E_DST, pk(ST_EXEC, E_RW | E_FL | E_PC, 0, 0, 4'b0000, 0, 0), "add");
    run_exec(16'hB1FF, 5'($urandom), 2, E_IMM | E_DST, pk(ST_EXEC, E_FL | E_PC, 0, 0, 4'b0010, 0, 0), "cmpi");
    run_exec(16'h01B2, 5'($urandom), $urandom_range(0, 2), E_SRC | E_DST, pk(ST_EXEC, E_FL | E_PC, 0, 0, 4'b0010, 0, 0), "cmp");
    run_exec(16'h0231, 5'($urandom), $urandom_range(0, 2), E_SRC | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b0101, 0, 0), "xor");
    run_exec(16'h9105, 5'($urandom), $urandom_range(0, 2), E_IMM | E_DST, pk(ST_EXEC, E_RW | E_FL | E_PC, 0, 0, 4'b0001, 0, 0), "subi");
    run_exec(16'hD1FF, 5'($urandom), $urandom_range(0, 2), E_IMM | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b0110, 0, 0), "movi");
    run_exec(16'hF0AB, 5'($urandom), $urandom_range(0, 2), E_IMM | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b0111, 0, 0), "lui");
    run_exec(16'h8140, 5'($urandom), $urandom_range(0, 2), E_SRC | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b1000, 0, 0), "lsh");
    run_exec(16'h8310, 5'($urandom), $urandom_range(0, 2), E_SRC | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b1000, 0, 0), "lshi");

    // Memory: LOAD with two-cycle late ack (6 cycles total), STOR with immediate ack
    run_exec(16'h4102, 5'($urandom), 0, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "load");
    mem_phase(1'b0, 1'b1, 2, "load");
    run_exec(16'h4142, 5'($urandom), 1, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "stor");
    mem_phase(1'b1, 1'b0, 0, "stor");

    // Branches and jumps; flags = {C,L,F,Z,N}
    run_exec(16'hC005, 5'b00010, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd1, 0, 0, 0, 0), "beq_taken");
    run_exec(16'hC005, 5'b11101, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd0, 0, 0, 0, 0), "beq_not");
    run_exec(16'hCF05, 5'b11111, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd0, 0, 0, 0, 0), "bnever");
    run_exec(16'hCE00, 5'b00000, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd1, 0, 0, 0, 0), "balways");
    run_exec(16'hCA00, 5'b10101, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd1, 0, 0, 0, 0), "blo_taken");
    run_exec(16'hCD00, 5'b11100, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd0, 0, 0, 0, 0), "bge_not");
    run_exec(16'hC400, 5'b01000, 0, 10'b0, pk(ST_EXEC, E_PC, 2'd1, 0, 0, 0, 0), "bhi_taken");
    run_exec(16'h41C0, 5'b00000, 1, E_DST, pk(ST_EXEC, E_PC, 2'd2, 0, 0, 0, 0), "jne_taken");
    run_exec(16'h41C0, 5'b00010, 1, E_DST, pk(ST_EXEC, E_PC, 2'd0, 0, 0, 0, 0), "jne_not");
    run_exec(16'h4080, 5'($urandom), 0, E_DST, pk(ST_EXEC, E_RW | E_PC, 2'd2, 2'd2, 0, 0, 0), "jal");

    // Undefined encodings
    run_exec(16'h40F0, 5'($urandom), 0, 10'b0, pk(ST_EXEC, E_PC, 0, 0, 0, 1, 0), "ill_40f0");
    run_exec(16'hE123, 5'($urandom), 0, 10'b0, pk(ST_EXEC, E_PC, 0, 0, 0, 1, 0), "ill_e123");
    run_exec(16'h0000, 5'($urandom), 0, 10'b0, pk(ST_EXEC, E_PC, 0, 0, 0, 1, 0), "ill_0000");
    run_exec(16'h8120, 5'($urandom), 0, 10'b0, pk(ST_EXEC, E_PC, 0, 0, 0, 1, 0), "ill_8120");

    // Reset mid-MEM and mid-FETCH abandons the access even with memAck present
    run_exec(16'h4102, 5'($urandom), 0, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "ld_rst");
    cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_MEM, E_MREQ | E_ASEL, 0, 0, 0, 0, 0), "ld_rst_mwait");
    do_reset("rst_mid_mem");
    cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_FETCH, E_MREQ, 0, 0, 0, 0, 0), "fetch_wait");
    do_reset("rst_mid_fetch");
    run_exec(16'h0152, 5'($urandom), 0, E_SRC | E_DST, pk(ST_EXEC, E_RW | E_FL | E_PC, 0, 0, 4'b0000, 0, 0), "add_after_rst");

`ifdef CTRL_MEM_TIMEOUT_EN
    run_exec(16'h0152, 5'($urandom), TMO - 1, E_SRC | E_DST, pk(ST_EXEC, E_RW | E_FL | E_PC, 0, 0, 4'b0000, 0, 0), "fetch_ack_edge");
    run_exec(16'h4102, 5'($urandom), 10, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "ld_edge");
    mem_phase(1'b0, 1'b1, TMO - 1, "ld_edge");
    for (int i = 0; i < TMO; i++)
      cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_FETCH, E_MREQ, 0, 0, 0, 0, 0), "to_fetch_wait");
    for (int i = 0; i < 3; i++)
      cyc(16'($urandom), 5'($urandom), 1'($urandom), pk(ST_HALT, 0, 0, 0, 0, 0, 1), "halted_fetch");
    do_reset("rst_from_halt");
    run_exec(16'h4142, 5'($urandom), 0, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "st_to");
    for (int i = 0; i < TMO; i++)
      cyc(16'($urandom), 5'($urandom), 1'b0, pk(ST_MEM, E_MREQ | E_MWE | E_ASEL, 0, 0, 0, 0, 0), "to_mem_wait");
    cyc(16'($urandom), 5'($urandom), 1'b1, pk(ST_HALT, 0, 0, 0, 0, 0, 1), "halted_mem");
    do_reset("rst_from_halt2");
`else
    run_exec(16'h0152, 5'($urandom), 20, E_SRC | E_DST, pk(ST_EXEC, E_RW | E_FL | E_PC, 0, 0, 4'b0000, 0, 0), "long_fetch");
    run_exec(16'h4102, 5'($urandom), 0, E_DST, pk(ST_EXEC, 0, 0, 0, 0, 0, 0), "long_ld");
    mem_phase(1'b0, 1'b1, 20, "long_ld");
`endif
    run_exec(16'h0231, 5'($urandom), 0, E_SRC | E_DST, pk(ST_EXEC, E_RW | E_PC, 0, 0, 4'b0101, 0, 0), "xor_final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15, meaning the number of memAck wait cycles before a halt (used only with CTRL_MEM_TIMEOUT_EN).
REQ-002 SHALL provide parameter TO_W, default 4, meaning the timeout counter width; MEM_TIMEOUT SHALL be less than 2^TO_W.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instr  input  16  instruction word; valid while memAck is high in FETCH.
REQ-006 flags  input  5  {C,L,F,Z,N} from the flag register.
REQ-007 memAck  input  1  memory completion strobe.
REQ-008 memReq, memWe, addrSel  output  1 each  memory request, write, and address source (0=PC, 1=register).
REQ-009 irEn, srcEn, dstEn, immEn  output  1 each  register load enables.
REQ-010 regWrite, flagsEn, pcEn  output  1 each  register-file write, flag update, and PC load.
REQ-011 pcSel, wbSel  output  2 each  PC source (0=PC+1, 1=PC+disp, 2=register) and write-back source (0=ALU, 1=memory, 2=PC+1).
REQ-012 aluOp  output  4  ALU operation code.
REQ-013 illegal, halted  output  1 each  illegal-opcode pulse and timeout halt indication.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM and HALT; all outputs SHALL be combinational from state, the latched instruction and inputs, with unlisted outputs 0.
REQ-015 IDLE SHALL go to FETCH unconditionally after one cycle.
REQ-016 FETCH SHALL assert memReq with addrSel=0, hold until memAck, assert irEn in the ack cycle, then go to DECODE.
REQ-017 DECODE SHALL assert srcEn+dstEn for register and shift forms, immEn+dstEn for immediate forms, and dstEn for LOAD, STOR, JAL and Jcond, then go to EXEC.
REQ-018 Register forms (op[15:12]=0000) SHALL decode ext[7:4] as ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011 and MOV 1101.
REQ-019 Immediate forms SHALL decode op[15:12] as ANDI 0001, ORI 0010, XORI 0011, ADDI 0101, SUBI 1001, CMPI 1011, MOVI 1101 and LUI 1111.
REQ-020 aluOp SHALL be ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, MOV 0110, LUI 0111 and LSH 1000.
REQ-021 ALU instructions in EXEC SHALL assert regWrite (wbSel=0), pcEn (pcSel=0) and flagsEn for ADD/SUB/CMP forms; CMP/CMPI SHALL NOT assert regWrite; each SHALL then go to FETCH.
REQ-022 Shift (op=1000, ext 0100 LSH, 0000/0001 LSHI) SHALL behave per REQ-021 with aluOp=1000 and flagsEn=0.
REQ-023 LOAD (0100/0000) and STOR (0100/0100) SHALL go EXEC→MEM.
REQ-024 MEM SHALL assert memReq with addrSel=1 and memWe=1 for STOR until memAck.
REQ-025 In the MEM ack cycle, LOAD SHALL assert regWrite with wbSel=1, and both LOAD and STOR SHALL assert pcEn with pcSel=0, then go to FETCH.
REQ-026 Bcond (op=1100) SHALL assert pcEn in EXEC with pcSel=1 when the condition is true and pcSel=0 otherwise.
REQ-027 Jcond (0100/1100) SHALL behave as Bcond but with pcSel=2 when taken.
REQ-028 JAL (0100/1000) SHALL assert regWrite (wbSel=2), pcEn and pcSel=2.
REQ-029 Condition instr[11:8] SHALL evaluate as EQ Z, NE !Z, CS C, CC !C, HI L, LS !L, GT N, LE !N, FS F, FC !F, LO !L&!Z, HS L|Z, LT !N&!Z, GE N|Z, 1110 always and 1111 never, using flags sampled in EXEC.
REQ-030 Undefined encodings SHALL pulse illegal for one cycle in EXEC, assert pcEn (pcSel=0), make no writes, and go to FETCH.
REQ-031 CPI SHALL be 3 cycles for ALU/branch instructions and 4 for LOAD/STOR when ack arrives on the first request cycle; each extra wait cycle SHALL add 1.

Reset
REQ-032 Reset SHALL force IDLE immediately, zeroing all outputs, the latched instruction and the timeout counter.
REQ-033 Reset mid-MEM or mid-FETCH SHALL abandon the access with no regWrite or pcEn.

Configuration
REQ-034 With CTRL_MEM_TIMEOUT_EN defined, the counter SHALL clear on entry to FETCH/MEM and increment each cycle memReq is high without memAck.
REQ-035 With CTRL_MEM_TIMEOUT_EN defined, reaching MEM_TIMEOUT SHALL go to HALT, where halted=1 and all other outputs are 0 until reset.
REQ-036 A memAck arriving in the same cycle the count reaches MEM_TIMEOUT SHALL take priority over the timeout.
REQ-037 Without CTRL_MEM_TIMEOUT_EN, waits SHALL be unbounded, HALT SHALL be unreachable and halted SHALL be tied to 0.

Verification
REQ-038 Reset release, instr=0x0152 (ADD), immediate memAck -> IDLE, FETCH, DECODE, EXEC; EXEC shows aluOp=0000, regWrite=1, flagsEn=1, pcEn=1.
REQ-039 instr=0xB1FF (CMPI) -> EXEC shows flagsEn=1, regWrite=0, aluOp=0010.
REQ-040 instr=0x4102 (LOAD), MEM memAck delayed 2 cycles -> memReq high 3 cycles, regWrite with wbSel=1 on the ack, 6-cycle instruction.
REQ-041 Bcond EQ (0xC005) with Z=1, then Z=0 -> pcSel=1, then pcSel=0; cond 1111 -> never taken.
REQ-042 With the macro and MEM_TIMEOUT=15, no ack -> halted=1 after 15 wait cycles; ack on cycle 15 -> normal completion.
REQ-043 instr=0x40F0 (illegal) -> one-cycle illegal pulse, pcEn=1, regWrite=0; reset asserted mid-MEM -> IDLE with no writes.
